// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: grant FSM states and the
// response entry carried down the latency pipe.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_entry_t;

endpackage

// File: rtl/mem_responder_if.sv
// Host-side request/response bus of the memory responder.
interface mem_responder_if;

    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );

endinterface

// File: rtl/mem_responder_pipe.sv
// Fixed-latency delay line for responses; entries are all-zero unless valid.
module mem_responder_pipe
    import mem_responder_pkg::*;
#(
    parameter int Latency = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       i_valid,
    input  rsp_entry_t i_rsp,
    output logic       o_valid,
    output rsp_entry_t o_rsp
);

    logic       r_valid [Latency];
    rsp_entry_t r_rsp   [Latency];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Latency; i++) begin
                r_valid[i] <= 1'b0;
                r_rsp[i]   <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_rsp[0]   <= i_rsp;
            for (int i = 1; i < Latency; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_rsp[i]   <= r_rsp[i-1];
            end
        end
    end

    assign o_valid = r_valid[Latency-1];
    assign o_rsp   = r_rsp[Latency-1];

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory slave with programmable grant delay, fixed
// response latency and a cap on outstanding requests.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int Depth          = 16384,
    parameter int GntDelay       = 0,
    parameter int RspLatency     = 1,
    parameter int MaxOutstanding = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    mem_responder_if.slave bus
);

    localparam int AW = $clog2(Depth);
    localparam int IW = $clog2(MaxOutstanding + 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_WAIT  = ST_WAIT;
    localparam logic [1:0] S_READY = ST_READY;

    logic [31:0]   r_mem [Depth];
    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [IW-1:0] r_inflight;

    logic          w_gnt;
    logic          w_room;
    logic          w_inrange;
    logic          w_rvalid;
    logic [AW-1:0] w_idx;
    logic          w_unused_addr;
    rsp_entry_t    w_rsp;
    rsp_entry_t    w_out;

    assign w_idx         = bus.addr_i[AW+1:2];
    assign w_inrange     = bus.addr_i[31:2] < 30'(Depth);
    assign w_unused_addr = ^bus.addr_i[1:0];

    // A response leaving this cycle frees its slot for a same-cycle grant
    assign w_room = (r_inflight != IW'(MaxOutstanding)) || w_rvalid;
    assign w_gnt  = !rst_i && bus.req_i && w_room &&
                    ((r_state == S_READY) ||
                     ((r_state == S_IDLE) && (GntDelay == 0)));

    always_ff @(posedge clk_i) begin
        if (w_gnt && bus.we_i && w_inrange) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rsp = '0;
        if (w_gnt) begin
            w_rsp.err = !w_inrange;
            if (w_inrange && !bus.we_i) begin
                w_rsp.rdata = r_mem[w_idx];
            end
        end
    end

    mem_responder_pipe #(
        .Latency (RspLatency)
    ) u_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_valid (w_gnt),
        .i_rsp   (w_rsp),
        .o_valid (w_rvalid),
        .o_rsp   (w_out)
    );

    // WAIT is left as the counter steps down to 1, so the grant
    // lands exactly GntDelay cycles after the request first appears
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_i && (GntDelay != 0)) begin
                        r_cnt   <= 4'(GntDelay);
                        r_state <= (GntDelay == 1) ? S_READY : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.req_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd2) begin
                            r_state <= S_READY;
                        end
                    end
                end
                S_READY: begin
                    if (!bus.req_i || w_gnt) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inflight <= '0;
        end else begin
            case ({w_gnt, w_rvalid})
                2'b10:   r_inflight <= r_inflight + IW'(1);
                2'b01:   r_inflight <= r_inflight - IW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign bus.gnt_o    = w_gnt;
    assign bus.rvalid_o = w_rvalid;
    assign bus.rdata_o  = w_out.rdata;
    assign bus.err_o    = w_out.err;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three configurations share one clock.
module tb_mem_responder;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   gc0, gc1, gtmp;

    exp_t qA[$];
    exp_t qB[$];
    exp_t qC[$];

    mem_responder_if ifA ();
    mem_responder_if ifB ();
    mem_responder_if ifC ();

    mem_responder uA (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifA.slave)
    );

    mem_responder #(
        .Depth    (64),
        .GntDelay (3)
    ) uB (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifB.slave)
    );

    mem_responder #(
        .Depth          (64),
        .RspLatency     (4),
        .MaxOutstanding (2)
    ) uC (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (ifC.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mon(input string tag, input exp_t e,
                       input logic err, input logic [31:0] rd);
        chk({tag, "_rsp_cycle"}, cyc, e.cyc);
        chk({tag, "_rsp_err"}, err, e.err);
        chk({tag, "_rsp_rdata"}, rd, e.rdata);
    endtask

    task automatic unexp(input string tag);
        n_tests++;
        n_fail++;
        $display("FAIL %s_unexpected_rvalid: got rvalid at cycle %0d expected none",
                 tag, cyc);
    endtask

    always @(negedge clk) begin
        if (ifA.rvalid_o === 1'b1) begin
            if (qA.size() == 0) unexp("A");
            else mon("A", qA.pop_front(), ifA.err_o, ifA.rdata_o);
        end
    end

    always @(negedge clk) begin
        if (ifB.rvalid_o === 1'b1) begin
            if (qB.size() == 0) unexp("B");
            else mon("B", qB.pop_front(), ifB.err_o, ifB.rdata_o);
        end
    end

    always @(negedge clk) begin
        if (ifC.rvalid_o === 1'b1) begin
            if (qC.size() == 0) unexp("C");
            else mon("C", qC.pop_front(), ifC.err_o, ifC.rdata_o);
        end
    end

    task automatic a_req(input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic eerr, input logic [31:0] erd,
                         output int gc);
        bit got;
        got = 0;
        gc = -1;
        ifA.req_i   = 1'b1;
        ifA.we_i    = we;
        ifA.be_i    = be;
        ifA.addr_i  = addr;
        ifA.wdata_i = wd;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (ifA.gnt_o === 1'b1) begin
                got = 1;
                gc = cyc;
                qA.push_back('{cyc + 1, eerr, erd});
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL A_gnt_timeout: got no grant expected grant for addr %h", addr);
        end
        @(posedge clk);
        #1;
        ifA.req_i = 1'b0;
    endtask

    task automatic b_hold(input logic we, input logic [31:0] wd,
                          input logic [31:0] erd, input string tag);
        ifB.req_i   = 1'b1;
        ifB.we_i    = we;
        ifB.be_i    = 4'hF;
        ifB.addr_i  = 32'h4;
        ifB.wdata_i = wd;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("%s_gnt_c%0d", tag, k), ifB.gnt_o, k == 3);
            if (ifB.gnt_o === 1'b1) qB.push_back('{cyc + 1, 1'b0, erd});
            if (k < 3) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        ifB.req_i = 1'b0;
    endtask

    initial begin
        ifA.req_i = 1'b1; ifA.we_i = 0; ifA.be_i = 0;
        ifA.addr_i = 0;   ifA.wdata_i = 0;
        ifB.req_i = 1'b0; ifB.we_i = 0; ifB.be_i = 0;
        ifB.addr_i = 0;   ifB.wdata_i = 0;
        ifC.req_i = 1'b0; ifC.we_i = 0; ifC.be_i = 0;
        ifC.addr_i = 0;   ifC.wdata_i = 0;

        repeat (2) @(negedge clk);
        chk("rst_A_gnt", ifA.gnt_o, 0);
        chk("rst_A_rvalid", ifA.rvalid_o, 0);
        chk("rst_A_err", ifA.err_o, 0);
        chk("rst_A_rdata", ifA.rdata_o, 0);
        chk("rst_C_rvalid", ifC.rvalid_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifA.req_i = 1'b0;

        // Config A: full write, back-to-back read
        a_req(1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 32'h0, gc0);
        a_req(0, 4'hF, 32'h10, 32'h0, 0, 32'hDEADBEEF, gc1);
        chk("A_b2b_read_cycle", gc1, gc0 + 1);
        // Byte-enable patterns
        a_req(1, 4'hF, 32'h20, 32'h11223344, 0, 32'h0, gtmp);
        a_req(1, 4'h2, 32'h20, 32'h0000AB00, 0, 32'h0, gtmp);
        a_req(0, 4'hF, 32'h20, 32'h0, 0, 32'h1122AB44, gtmp);
        a_req(1, 4'h9, 32'h20, 32'hAA0000BB, 0, 32'h0, gtmp);
        a_req(0, 4'hF, 32'h20, 32'h0, 0, 32'hAA22ABBB, gtmp);
        // Out-of-range accesses must error and not alias into memory
        a_req(1, 4'hF, 32'h0, 32'hCAFEF00D, 0, 32'h0, gtmp);
        a_req(0, 4'hF, 32'h0001_0000, 32'h0, 1, 32'h0, gtmp);
        a_req(1, 4'hF, 32'h0001_0000, 32'h12345678, 1, 32'h0, gtmp);
        a_req(1, 4'hF, 32'h8000_0010, 32'h0BADF00D, 1, 32'h0, gtmp);
        a_req(0, 4'hF, 32'h0, 32'h0, 0, 32'hCAFEF00D, gtmp);
        a_req(0, 4'hF, 32'h10, 32'h0, 0, 32'hDEADBEEF, gtmp);
        // Last word in range; low address bits ignored
        a_req(1, 4'hF, 32'hFFFC, 32'h600DCAFE, 0, 32'h0, gtmp);
        a_req(0, 4'hF, 32'hFFFF, 32'h0, 0, 32'h600DCAFE, gtmp);
        a_req(0, 4'hF, 32'h13, 32'h0, 0, 32'hDEADBEEF, gtmp);
        repeat (4) @(posedge clk);
        #1;

        // Config B: grant delay of 3
        b_hold(1, 32'h55, 32'h0, "B_hold");
        repeat (3) @(posedge clk);
        #1;
        ifB.req_i = 1'b1;
        ifB.we_i  = 1'b0;
        @(negedge clk);
        chk("B_drop_c0_gnt", ifB.gnt_o, 0);
        @(posedge clk);
        #1;
        ifB.req_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("B_drop_idle_c%0d", k + 1), ifB.gnt_o, 0);
        end
        @(posedge clk);
        #1;
        b_hold(0, 32'h0, 32'h55, "B_after_drop");
        repeat (4) @(posedge clk);
        #1;

        // Config C: latency 4, two outstanding
        ifC.req_i   = 1'b1;
        ifC.we_i    = 1'b1;
        ifC.be_i    = 4'hF;
        ifC.addr_i  = 32'h8;
        ifC.wdata_i = 32'h77;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("C_gnt_c%0d", k), ifC.gnt_o, (k < 2) || (k == 4));
            if (k == 4) chk("C_rvalid_c4", ifC.rvalid_o, 1);
            if (ifC.gnt_o === 1'b1) qC.push_back('{cyc + 4, 1'b0, 32'h0});
            if (k < 4) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        ifC.req_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        ifC.req_i = 1'b1;
        ifC.we_i  = 1'b0;
        @(negedge clk);
        chk("C_read_gnt", ifC.gnt_o, 1);
        if (ifC.gnt_o === 1'b1) qC.push_back('{cyc + 4, 1'b0, 32'h77});
        @(posedge clk);
        #1;
        ifC.req_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Reset with two responses in flight: they must vanish
        ifC.req_i = 1'b1;
        @(negedge clk);
        chk("C_pre_rst_gnt0", ifC.gnt_o, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("C_pre_rst_gnt1", ifC.gnt_o, 1);
        @(posedge clk);
        #1;
        ifC.req_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        ifC.req_i = 1'b1;
        @(negedge clk);
        chk("C_in_rst_gnt", ifC.gnt_o, 0);
        chk("C_in_rst_rvalid", ifC.rvalid_o, 0);
        chk("C_in_rst_err", ifC.err_o, 0);
        chk("C_in_rst_rdata", ifC.rdata_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifC.req_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("C_post_rst_quiet_c%0d", k), ifC.rvalid_o, 0);
        end
        @(posedge clk);
        #1;
        ifC.req_i = 1'b1;
        @(negedge clk);
        chk("C_post_rst_gnt", ifC.gnt_o, 1);
        if (ifC.gnt_o === 1'b1) qC.push_back('{cyc + 4, 1'b0, 32'h77});
        @(posedge clk);
        #1;
        ifC.req_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        chk("A_queue_drained", qA.size(), 0);
        chk("B_queue_drained", qB.size(), 0);
        chk("C_queue_drained", qC.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
